// File: rtl/crc32_seq.sv
// Bit-serial reflected CRC-32 (poly 0xEDB88320) over a byte stream, one bit per clock.
// Define CRC32_SEQ_CHECK_EN to add the crc_ok receive-side residue check output.
module crc32_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        abort,
    input  logic        crc_ack,
    output logic        crc_valid,
    output logic [31:0] crc,
    output logic        busy
`ifdef CRC32_SEQ_CHECK_EN
    ,
    output logic        crc_ok
`endif
);

    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        last_q, last_d;
    logic        fb;

    assign fb = lfsr_q[0] ^ shift_q[0];

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        last_d    = last_q;
        in_ready  = 1'b0;
        crc_valid = 1'b0;
        crc       = 32'h0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                in_ready = ~abort;
                if (in_valid && !abort) begin
                    shift_d = in_data;
                    last_d  = in_last;
                    cnt_d   = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                lfsr_d  = {1'b0, lfsr_q[31:1]} ^ ({32{fb}} & POLY);
                shift_d = {1'b0, shift_q[7:1]};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                crc_valid = 1'b1;
                crc       = ~lfsr_q;
                if (crc_ack) begin
                    state_d = IDLE;
                    lfsr_d  = INIT;
                end
            end
            default: begin
                state_d = IDLE;
                lfsr_d  = INIT;
            end
        endcase

        // abort overrides any handshake, shift step or ack in the same cycle
        if (abort) begin
            state_d = IDLE;
            lfsr_d  = INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            lfsr_q  <= INIT;
            cnt_q   <= 3'd0;
            shift_q <= 8'h00;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            last_q  <= last_d;
        end
    end

`ifdef CRC32_SEQ_CHECK_EN
    // A frame carrying its own CRC leaves the fixed CRC-32 residue in the register
    assign crc_ok = (state_q == DONE) && (lfsr_q == RESIDUE);
`endif

endmodule
